button_ctrl: RTL and testbench

BUTTON_CTRL -- requirements
Module: button_ctrl

---
 rtl/button_ctrl.sv | 176 +++++++++++++++++
 tb/tb_button_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// ---------------------------------------------------------------------------
// button_ctrl
//
// Purpose:
//   Debounces a raw, active-low push-button pin and reports presses to a CPU
//   bus decoder. The raw pin is brought into the clk domain with a two-flop
//   synchronizer. A four-state FSM then accepts a new level only after the
//   synchronized input has differed from the current debounced level for
//   DEBOUNCE_CYCLES consecutive cycles.
//
// Optional feature (macro BTN_LATCH_EN):
//   defined   - a sticky press flag is set on each debounced press and cleared
//               by a bus read (btn_ren). btn_out = ~flag. Set wins over clear.
//   undefined - no flag; btn_ren is ignored and btn_out = ~btn_level.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to change level
//                    (default 270000 = 10 ms at 27 MHz; legal 2..2^24)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   btn_in     in   raw asynchronous button pin, 0 = pressed
//   btn_ren    in   one-cycle read strobe from the bus decoder
//   btn_out    out  0 = press reported, 1 = nothing to report
//   btn_level  out  registered debounced level, 1 = button held
// ---------------------------------------------------------------------------
module button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic btn_ren,
  output logic btn_out,
  output logic btn_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  // The cycle that first sees the new input value is the one that moves the
  // FSM into a pending state, so it already counts as stable cycle #1. The
  // counter therefore covers cycles 2..DEBOUNCE_CYCLES; when it holds this
  // value and the input still agrees, this cycle makes its count reach
  // DEBOUNCE_CYCLES-1 and the level flips on the coming edge.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    S_RELEASED        = 2'd0,
    S_PRESS_PENDING   = 2'd1,
    S_PRESSED         = 2'd2,
    S_RELEASE_PENDING = 2'd3
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_sync;
  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_level;
  logic          w_level_next;
  logic          w_press_evt;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer; resets to the idle (released) pin level.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync = r_sync2;

  // -------------------------------------------------------------------------
  // FSM process 1: state, counter and registered level.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RELEASED;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_level <= w_level_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next state and next counter value. The counter defaults to
  // zero, so it is cleared on every entry to a pending state, on every revert
  // and on every completed transition, and stays zero in stable states.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    case (r_state)
      S_RELEASED: begin
        if (!w_sync) begin
          w_state_next = S_PRESS_PENDING;
        end
      end
      S_PRESS_PENDING: begin
        if (w_sync) begin
          w_state_next = S_RELEASED;         // glitch: back to stable
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_PRESSED;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_PRESSED: begin
        if (w_sync) begin
          w_state_next = S_RELEASE_PENDING;
        end
      end
      S_RELEASE_PENDING: begin
        if (!w_sync) begin
          w_state_next = S_PRESSED;          // glitch: back to stable
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_RELEASED;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = S_RELEASED;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: outputs. The level is decoded from the next state so the
  // registered level changes on the same edge as the state does.
  // -------------------------------------------------------------------------
  always_comb begin
    w_level_next = (w_state_next == S_PRESSED) ||
                   (w_state_next == S_RELEASE_PENDING);
    w_press_evt  = (r_state == S_PRESS_PENDING) &&
                   (w_state_next == S_PRESSED);
  end

  assign btn_level = r_level;

`ifdef BTN_LATCH_EN
  // Sticky press flag: a press always wins over a read in the same cycle so
  // a press arriving during the read is never lost.
  logic r_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag <= 1'b0;
    end else if (w_press_evt) begin
      r_flag <= 1'b1;
    end else if (btn_ren) begin
      r_flag <= 1'b0;
    end
  end

  assign btn_out = ~r_flag;
`else
  // Live level reporting; the read strobe and press pulse have no consumer.
  logic w_unused;

  assign w_unused = btn_ren ^ w_press_evt;
  assign btn_out  = ~r_level;
`endif

endmodule

// File: tb/tb_button_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_ctrl
//
// Directed and random stimulus for button_ctrl with DEBOUNCE_CYCLES = 4.
// Expected outputs come from a run-length model: the synchronized pin is the
// raw pin delayed two cycles, and the debounced level flips one cycle after
// the synchronized pin has disagreed with it for DEBOUNCE_CYCLES cycles in a
// row. Works in both configurations (BTN_LATCH_EN defined or not).
// ---------------------------------------------------------------------------
module tb_button_ctrl;

  localparam int D = 4;

`ifdef BTN_LATCH_EN
  localparam logic LATCH = 1'b1;
`else
  localparam logic LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_ren;
  logic btn_out;
  logic btn_level;

  int total = 0;
  int bad   = 0;

  // reference model state (values seen during the current cycle)
  logic m_d1;
  logic m_d2;
  logic m_level;
  logic m_flag;
  int   m_run;

  always #5 clk = ~clk;

  button_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_ren   (btn_ren),
    .btn_out   (btn_out),
    .btn_level (btn_level)
  );

  function automatic logic exp_out();
    if (LATCH) return ~m_flag;
    return ~m_level;
  endfunction

  task automatic check(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Advance the model across one rising edge given the inputs of the cycle.
  task automatic model_edge(input logic b, input logic r, input logic ren);
    logic s;
    logic nl;
    logic evt;
    if (r) begin
      m_d1    = 1'b1;
      m_d2    = 1'b1;
      m_level = 1'b0;
      m_flag  = 1'b0;
      m_run   = 0;
    end else begin
      s   = m_d2;
      nl  = m_level;
      evt = 1'b0;
      if ((~s) != m_level) begin
        m_run++;
        if (m_run == D) begin
          nl    = ~m_level;
          m_run = 0;
          evt   = nl;
        end
      end else begin
        m_run = 0;
      end
      if (evt) m_flag = 1'b1;
      else if (ren) m_flag = 1'b0;
      m_d2    = m_d1;
      m_d1    = b;
      m_level = nl;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic step(input logic b, input logic r, input logic ren);
    btn_in  = b;
    rst     = r;
    btn_ren = ren;
    @(posedge clk);
    model_edge(b, r, ren);
    #1;
    check("level_model", btn_level, m_level);
    check("out_model", btn_out, exp_out());
    $display("step btn_in=%b rst=%b ren=%b -> level=%b out=%b", b, r, ren, btn_level, btn_out);
  endtask

  initial begin
    int c;
    int len;
    logic v;
    btn_in  = 1'b1;
    rst     = 1'b1;
    btn_ren = 1'b0;
    m_d1 = 1'b1; m_d2 = 1'b1; m_level = 1'b0; m_flag = 1'b0; m_run = 0;

    // reset state
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("rst_level", btn_level, 1'b0);
    check("rst_out", btn_out, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b0);

    // clean press, read strobe at cycle 10 while held
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 1'b0, (k == 10));
      c = k + 1;
      if (c == 5) check("press_c5_level", btn_level, 1'b0);
      if (c == 5) check("press_c5_out", btn_out, 1'b1);
      if (c == 6) check("press_c6_level", btn_level, 1'b1);
      if (c == 6) check("press_c6_out", btn_out, 1'b0);
      if (c == 10) check("read_c10_out", btn_out, 1'b0);
      if (c >= 12) check("read_after_out", btn_out, LATCH ? 1'b1 : 1'b0);
    end

    // release, then re-press gives a fresh report
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0);
      c = k + 1;
      if (c == 5) check("rel_c5_level", btn_level, 1'b1);
      if (c == 6) check("rel_c6_level", btn_level, 1'b0);
      if (c == 6) check("rel_c6_out", btn_out, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      c = k + 1;
      if (c == 6) check("repress_c6_out", btn_out, 1'b0);
    end
    repeat (8) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("cleared_out", btn_out, 1'b1);

    // glitch: three low cycles then high
    for (int k = 0; k < 13; k++) begin
      step((k < 3) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      check("glitch_level", btn_level, 1'b0);
      check("glitch_out", btn_out, 1'b1);
    end

    // press with read strobe on the press-event cycle (set wins)
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, (k == 5));
      c = k + 1;
      if (c == 5) check("sim_c5_level", btn_level, 1'b0);
      if (c == 6) check("sim_c6_level", btn_level, 1'b1);
      if (c >= 6) check("sim_out", btn_out, 1'b0);
    end
    repeat (8) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);

    // reset mid-debounce at cycle 3, pin held low
    for (int k = 0; k < 12; k++) begin
      step(1'b0, (k == 3), 1'b0);
      c = k + 1;
      if (c >= 3 && c <= 9) check("rstmid_out", btn_out, 1'b1);
      if (c == 9) check("rstmid_c9_level", btn_level, 1'b0);
      if (c == 10) check("rstmid_c10_level", btn_level, 1'b1);
      if (c == 10) check("rstmid_c10_out", btn_out, 1'b0);
    end

    // reset while pressed, button held through reset release
    for (int k = 0; k < 9; k++) begin
      step(1'b0, (k == 0), 1'b0);
      c = k + 1;
      if (c == 1) check("held_rst_out", btn_out, 1'b1);
      if (c == 6) check("held_c6_level", btn_level, 1'b0);
      if (c == 7) check("held_c7_level", btn_level, 1'b1);
      if (c == 7) check("held_c7_out", btn_out, 1'b0);
    end
    repeat (8) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);

    // press/release 20 cycles each with random read strobes
    repeat (20) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    repeat (20) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));

    // random runs of pin level, read strobes and rare resets
    repeat (80) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        step(v, ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
